// File: rtl/inst_queue_pkg.sv
// Shared constants for the two-wide fetch-to-decode instruction queue.
package inst_queue_pkg;

    localparam int IQ_WIDTH = 16;
    localparam int IQ_DEPTH = 8;
    localparam int IQ_PTR_W = $clog2(IQ_DEPTH);

    // Decode substitutes this word in any slot whose out_valid is low.
    localparam logic [IQ_WIDTH-1:0] IQ_NOP = 16'h0000;

    // Number of fetch slots accepted; slot 1 only counts behind a valid slot 0.
    function automatic logic [1:0] iq_slot_count(input logic v0, input logic v1);
        return {1'b0, v0} + {1'b0, v0 & v1};
    endfunction

endpackage

// File: rtl/iq_entry.sv
// One queue storage entry: a word register with write enable and async clear.
module iq_entry #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Hold the stored word, loading it only when the parent selects this entry.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dual_issue_inst_queue.sv
// Two-wide circular instruction queue between fetch and decode.
// Reads are combinational from storage; writes become visible after the edge.
module dual_issue_inst_queue
    import inst_queue_pkg::*;
#(
    parameter  int WIDTH = IQ_WIDTH,
    parameter  int DEPTH = IQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             in_valid0,
    input  logic             in_valid1,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    output logic             in_ready,
    output logic             out_valid0,
    output logic             out_valid1,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    input  logic             deq0,
    input  logic             deq1,
    output logic [PTR_W:0]   count
);

    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [PTR_W-1:0] wr_ptr_p1;
    logic [PTR_W-1:0] rd_ptr_p1;

    logic             enq0, enq1;
    logic             deq0_ok, deq1_ok;
    logic [1:0]       n_enq, n_deq;

    logic             entry_we [DEPTH];
    logic [WIDTH-1:0] entry_d  [DEPTH];
    logic [WIDTH-1:0] mem_q    [DEPTH];

    assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);
    assign rd_ptr_p1 = rd_ptr_q + PTR_W'(1);

    // in_ready looks only at the registered count, so a full queue stays
    // closed even when decode drains in the same cycle.
    assign in_ready   = (count_q <= CNT_W'(DEPTH - 2));
    assign out_valid0 = (count_q != '0);
    assign out_valid1 = (count_q >= CNT_W'(2));
    assign out_data0  = mem_q[rd_ptr_q];
    assign out_data1  = mem_q[rd_ptr_p1];
    assign count      = count_q;

    // Flush discards whatever fetch presents in the same cycle.
    assign enq0  = in_ready && !flush && in_valid0;
    assign enq1  = enq0 && in_valid1;
    assign n_enq = flush ? 2'd0 : (in_ready ? iq_slot_count(in_valid0, in_valid1) : 2'd0);

    // Decode requests are clamped to what is actually present; deq1 alone is ignored.
    assign deq0_ok = deq0 && (count_q != '0);
    assign deq1_ok = deq0_ok && deq1 && (count_q >= CNT_W'(2));
    assign n_deq   = {1'b0, deq0_ok} + {1'b0, deq1_ok};

    // Decode slot 0 and slot 1 writes into per-entry enables; the two
    // target addresses are always distinct so at most one matches each entry.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_we[i] = 1'b0;
            entry_d[i]  = '0;
            if (enq0 && (wr_ptr_q == PTR_W'(i))) begin
                entry_we[i] = 1'b1;
                entry_d[i]  = in_data0;
            end else if (enq1 && (wr_ptr_p1 == PTR_W'(i))) begin
                entry_we[i] = 1'b1;
                entry_d[i]  = in_data1;
            end
        end
    end

    // Next-state pointer and occupancy arithmetic; flush overrides everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(n_enq);
        rd_ptr_d = rd_ptr_q + PTR_W'(n_deq);
        count_d  = count_q + CNT_W'(n_enq) - CNT_W'(n_deq);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        iq_entry #(
            .WIDTH (WIDTH)
        ) u_entry (
            .clk (clk),
            .clr (clr),
            .we  (entry_we[g]),
            .d   (entry_d[g]),
            .q   (mem_q[g])
        );
    end

endmodule

// File: tb/tb_dual_issue_inst_queue.sv
// Scoreboard bench for the two-wide instruction queue.
module tb_dual_issue_inst_queue;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             clr;
    logic             flush;
    logic             in_valid0, in_valid1;
    logic [WIDTH-1:0] in_data0, in_data1;
    logic             in_ready;
    logic             out_valid0, out_valid1;
    logic [WIDTH-1:0] out_data0, out_data1;
    logic             deq0, deq1;
    logic [3:0]       count;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] exp_q[$];

    always #5 clk = ~clk;

    dual_issue_inst_queue #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .flush      (flush),
        .in_valid0  (in_valid0),
        .in_valid1  (in_valid1),
        .in_data0   (in_data0),
        .in_data1   (in_data1),
        .in_ready   (in_ready),
        .out_valid0 (out_valid0),
        .out_valid1 (out_valid1),
        .out_data0  (out_data0),
        .out_data1  (out_data1),
        .deq0       (deq0),
        .deq1       (deq1),
        .count      (count)
    );

    // Occupancy must stay within 0..DEPTH; an underflow wraps to a large value.
    always @(negedge clk) begin
        if (!clr) begin
            assert (count <= 4'(DEPTH))
            else begin
                n_errors++;
                $display("FAIL count_bound: count=%0d limit=%0d", count, DEPTH);
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string ctx);
        int sz;
        sz = exp_q.size();
        check_val({ctx, ".count"},    32'(count),      32'(sz));
        check_val({ctx, ".in_ready"}, 32'(in_ready),   32'(DEPTH - sz >= 2));
        check_val({ctx, ".valid0"},   32'(out_valid0), 32'(sz >= 1));
        check_val({ctx, ".valid1"},   32'(out_valid1), 32'(sz >= 2));
        if (sz >= 1) check_val({ctx, ".data0"}, 32'(out_data0), 32'(exp_q[0]));
        if (sz >= 2) check_val({ctx, ".data1"}, 32'(out_data1), 32'(exp_q[1]));
    endtask

    // Drive one cycle, check presented outputs, update the scoreboard, cross the edge.
    task automatic step(input logic v0, input logic v1,
                        input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                        input logic q0, input logic q1, input logic fl,
                        input string ctx);
        int sz;
        in_valid0 = v0;
        in_valid1 = v1;
        in_data0  = d0;
        in_data1  = d1;
        deq0      = q0;
        deq1      = q1;
        flush     = fl;
        #1;
        check_outputs(ctx);
        sz = exp_q.size();
        if (fl) begin
            exp_q.delete();
        end else begin
            if (q0 && sz >= 1) begin
                void'(exp_q.pop_front());
                if (q1 && sz >= 2) void'(exp_q.pop_front());
            end
            if ((DEPTH - sz >= 2) && v0) begin
                exp_q.push_back(d0);
                if (v1) exp_q.push_back(d1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string ctx);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, ctx);
    endtask

    initial begin
        clr       = 1'b0;
        flush     = 1'b0;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        in_data0  = '0;
        in_data1  = '0;
        deq0      = 1'b0;
        deq1      = 1'b0;

        // Reset and idle.
        #2 clr = 1'b1;
        #10;
        check_outputs("reset");
        check_val("reset.data0", 32'(out_data0), 32'h0);
        check_val("reset.data1", 32'(out_data1), 32'h0);
        #1 clr = 1'b0;
        @(posedge clk);
        #1;
        idle("idle");

        // Fill with four dual writes, then attempt a write while full.
        for (int k = 0; k < 4; k++)
            step(1'b1, 1'b1, 16'(16'h1001 + 2 * k), 16'(16'h1002 + 2 * k), 1'b0, 1'b0, 1'b0, "fill");
        step(1'b1, 1'b1, 16'hdead, 16'hbeef, 1'b0, 1'b0, 1'b0, "full_drop");

        // Drain two from full, refill across the wrap, then drain to empty.
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, "drain_full");
        step(1'b1, 1'b1, 16'h2001, 16'h2002, 1'b0, 1'b0, 1'b0, "wrap_enq");
        for (int k = 0; k < 10 && exp_q.size() > 0; k++)
            step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, "drain");
        idle("empty");

        // Simultaneous single enqueue and dual dequeue at count 3.
        step(1'b1, 1'b0, 16'h5001, '0, 1'b0, 1'b0, 1'b0, "sim_fill");
        step(1'b1, 1'b0, 16'h5002, '0, 1'b0, 1'b0, 1'b0, "sim_fill");
        step(1'b1, 1'b0, 16'h5003, '0, 1'b0, 1'b0, 1'b0, "sim_fill");
        step(1'b1, 1'b0, 16'h5004, '0, 1'b1, 1'b1, 1'b0, "sim_enq_deq");

        // deq1 alone, single dequeue, clamped dual dequeue, slot1-only write.
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, "deq1_only");
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, "deq0_only");
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, "deq_clamp");
        step(1'b0, 1'b1, 16'h5555, 16'h5555, 1'b0, 1'b0, 1'b0, "v1_only");
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, "empty_deq");
        idle("after_illegal");

        // Flush beats a concurrent dual enqueue and dequeue.
        step(1'b1, 1'b1, 16'h6001, 16'h6002, 1'b0, 1'b0, 1'b0, "pre_flush");
        step(1'b1, 1'b1, 16'h6003, 16'h6004, 1'b0, 1'b0, 1'b0, "pre_flush");
        step(1'b1, 1'b0, 16'h6005, '0, 1'b0, 1'b0, 1'b0, "pre_flush");
        step(1'b1, 1'b1, 16'h6006, 16'h6007, 1'b1, 1'b0, 1'b1, "flush");
        step(1'b1, 1'b0, 16'h3001, '0, 1'b0, 1'b0, 1'b0, "post_flush");
        idle("flush_refill");

        // Random traffic to exercise wrap at every pointer alignment.
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 16'(16'h4000 + 2 * k), 16'(16'h4001 + 2 * k),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 31) == 0), "rand");
        end

        // Asynchronous clear in the middle of operation.
        step(1'b1, 1'b1, 16'h7001, 16'h7002, 1'b0, 1'b0, 1'b0, "pre_clr");
        step(1'b1, 1'b1, 16'h7003, 16'h7004, 1'b0, 1'b0, 1'b0, "pre_clr");
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        clr       = 1'b1;
        #1;
        exp_q.delete();
        check_outputs("mid_clr");
        #1 clr = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b1, 16'h8001, 16'h8002, 1'b0, 1'b0, 1'b0, "after_clr");
        idle("after_clr_vis");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
